rx_word_fifo: RTL and testbench
===============================

# rx_word_fifo

Word FIFO between `rx_top` and `spi_master` on the receive path. It absorbs 16-bit words from the Econet receiver while the SPI link to the host is busy. It presents the words in order to the SPI side with a strobe/accept handshake, and it counts words it has to drop. Everything runs in the `mclk` domain, downstream of the receiver's clock crossing.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 words (16).
- `THRESHOLD`, default 8: occupancy at or above which `level_hi` asserts; legal range 1..2^DEPTH_LOG2.

Ports:
- `mclk`  in  1: system clock; all logic rising-edge.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  16: word from receiver.
- `in_strobe`  in  1: one-cycle pulse, `in_data` valid this cycle.
- `out_data`  out  16: head-of-FIFO word, meaningful while `out_valid`=1.
- `out_valid`  out  1: FIFO non-empty.
- `out_accept`  in  1: one-cycle pulse from SPI side, pops head word.
- `count`  out  DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `level_hi`  out  1: registered, `count` >= THRESHOLD.
- `overflow`  out  1: sticky, at least one word dropped.
- `dropped`  out  8: saturating count of dropped words.
- `overflow_clear`  in  1: one-cycle pulse, clears `overflow` and `dropped`.

## Operation
- Storage: 2^DEPTH_LOG2 x 16 register array.
  - Write pointer and read pointer are each DEPTH_LOG2 bits and wrap modulo depth.
  - `count` is held as a separate register.
- `out_data` = storage[read pointer], decoded directly from registers (first-word-fall-through).
- Pop: when `out_accept`=1 and `out_valid`=1, increment the read pointer. `out_accept` while `out_valid`=0 is ignored: no pointer or count change, no error.
- Push: when `in_strobe`=1 and either `count` < depth or a pop occurs in the same cycle, write `in_data` at the write pointer and increment the write pointer.
- Drop: when `in_strobe`=1, `count` = depth and no pop this cycle:
  - the word is discarded and storage is unchanged;
  - `overflow` sets to 1;
  - `dropped` increments, saturating at 255.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- `out_valid` = (`count` != 0), taken from the count register.
- `level_hi` is registered from the next-state count.
- Simultaneous drop and `overflow_clear` in one cycle: set wins; `overflow`=1 and `dropped`=1.
- `overflow_clear` alone: `overflow`=0, `dropped`=0 next cycle.
- No ordering violation under any combination: words leave in arrival order, minus the dropped ones.

## Timing
- Reset (sampled high on a `mclk` edge) clears pointers, count, storage, `overflow` and `dropped`. The next cycle shows `out_valid`=0, `out_data`=0, `count`=0, `level_hi`=0, `overflow`=0, `dropped`=0.
- Reset mid-operation discards all stored words. A `in_strobe` in the reset cycle is ignored.
- Latency: `in_strobe` in cycle N into an empty FIFO gives `out_valid`=1 and `out_data`=that word in cycle N+1. There is no same-cycle bypass.
- Pop in cycle N: the next word (or `out_valid`=0) appears in cycle N+1.
- Full + `in_strobe` + `out_accept` in the same cycle: the head is popped, the new word is stored at the tail, `count` stays at depth, and there is no drop.
- Empty + `in_strobe` + `out_accept` in the same cycle: the accept is ignored and the word is stored, giving `count`=1.
- Sustained back-to-back push and pop, one word per cycle, holds `count` constant.
- `level_hi` changes in the same cycle `count` crosses THRESHOLD; both update on the same edge.

## Test plan
- Reset, then push 0x1234, 0xABCD on consecutive cycles, then accept twice -> `out_data` reads 0x1234 then 0xABCD; `out_valid` drops one cycle after the second accept; `count` goes 1,2,1,0.
- Push 16 words 0x0000..0x000F, then push 0xFFFF -> `count`=16, `overflow`=1, `dropped`=1. Draining yields 0x0000..0x000F only. `level_hi` rises when `count` reaches 8 and falls when `count` drops to 7.
- Hold full, pulse `in_strobe` and `out_accept` together with 0x5555 -> head popped, `count`=16, `overflow` unchanged. After draining, 0x5555 is the last word.
- Push 300 words with no accepts -> `dropped` saturates at 255. `overflow_clear` -> `overflow`=0, `dropped`=0. Pulse `overflow_clear` together with a drop -> `overflow`=1, `dropped`=1.
- Run 40 words with random `out_accept` to force pointer wrap, assert `reset` midway -> next cycle `count`=0, `out_valid`=0, `out_data`=0. The subsequent push of 0x0042 appears one cycle later.
- Accept pulses while empty -> no change to `count`, pointers or flags.

Source files
------------

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: first-word-fall-through word buffer between the Econet
// receiver and the SPI master. Words that arrive while the buffer is full
// and nothing is leaving are discarded and counted.
module rx_word_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int THRESHOLD  = 8
) (
   input  logic                  mclk,
   input  logic                  reset,
   input  logic [15:0]           in_data,
   input  logic                  in_strobe,
   output logic [15:0]           out_data,
   output logic                  out_valid,
   input  logic                  out_accept,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  level_hi,
   output logic                  overflow,
   output logic [7:0]            dropped,
   input  logic                  overflow_clear
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] THRESH_C = (DEPTH_LOG2+1)'(THRESHOLD);

   logic [15:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count_q;
   logic [DEPTH_LOG2:0]   count_next;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic                  full;

   // Handshake decode; a pop frees a slot, so a full FIFO can still accept
   // a word in the same cycle its head leaves.
   always_comb begin
      full       = (count_q == DEPTH_C);
      pop        = out_accept && (count_q != '0);
      push       = in_strobe && (!full || pop);
      drop       = in_strobe && full && !pop;
      count_next = count_q;
      if (push && !pop)
         count_next = count_q + 1'b1;
      else if (pop && !push)
         count_next = count_q - 1'b1;
   end

   // Storage, pointers, occupancy and the registered high-water flag.
   always_ff @(posedge mclk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         level_hi <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count_q  <= count_next;
         level_hi <= (count_next >= THRESH_C);
      end
   end

   // Drop bookkeeping; a drop in the same cycle as a clear wins, so the
   // lost word is never hidden from the host.
   always_ff @(posedge mclk) begin
      if (reset) begin
         overflow <= 1'b0;
         dropped  <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (overflow_clear)
            dropped <= 8'd1;
         else if (dropped != 8'hFF)
            dropped <= dropped + 8'd1;
      end else if (overflow_clear) begin
         overflow <= 1'b0;
         dropped  <= '0;
      end
   end

   assign out_data  = mem[rd_ptr];
   assign out_valid = (count_q != '0);
   assign count     = count_q;

endmodule

// File: tb/tb_rx_word_fifo.sv
// Directed bench for rx_word_fifo. Inputs change 1 ns after a rising edge;
// outputs are checked 1 ns after the edge that consumed them.
module tb_rx_word_fifo;

   logic        mclk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_data = '0;
   logic        in_strobe = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_accept = 1'b0;
   logic [4:0]  count;
   logic        level_hi;
   logic        overflow;
   logic [7:0]  dropped;
   logic        overflow_clear = 1'b0;

   int tests = 0;
   int fails = 0;

   rx_word_fifo #(.DEPTH_LOG2(4), .THRESHOLD(8)) dut (
      .mclk(mclk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
      .out_data(out_data), .out_valid(out_valid), .out_accept(out_accept),
      .count(count), .level_hi(level_hi), .overflow(overflow),
      .dropped(dropped), .overflow_clear(overflow_clear)
   );

   always #5 mclk = ~mclk;

   task automatic tick();
      @(posedge mclk);
      #1;
      in_strobe      = 1'b0;
      out_accept     = 1'b0;
      overflow_clear = 1'b0;
      reset          = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", out_data); end
      tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
      tests++; if (level_hi !== 1'b0) begin fails++; $display("FAIL reset_level got %0b want 0", level_hi); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b want 0", overflow); end
      tests++; if (dropped !== 8'd0) begin fails++; $display("FAIL reset_dropped got %0d want 0", dropped); end
   endtask

   task automatic test_basic();
      in_data = 16'h1234; in_strobe = 1'b1; tick();
      tests++; if (count !== 5'd1 || out_data !== 16'h1234 || out_valid !== 1'b1) begin fails++;
         $display("FAIL basic_p1 got cnt=%0d data=%h v=%0b want 1 1234 1", count, out_data, out_valid); end
      in_data = 16'hABCD; in_strobe = 1'b1; tick();
      tests++; if (count !== 5'd2 || out_data !== 16'h1234) begin fails++;
         $display("FAIL basic_p2 got cnt=%0d data=%h want 2 1234", count, out_data); end
      out_accept = 1'b1; tick();
      tests++; if (count !== 5'd1 || out_data !== 16'hABCD || out_valid !== 1'b1) begin fails++;
         $display("FAIL basic_a1 got cnt=%0d data=%h v=%0b want 1 abcd 1", count, out_data, out_valid); end
      out_accept = 1'b1; tick();
      tests++; if (count !== 5'd0 || out_valid !== 1'b0) begin fails++;
         $display("FAIL basic_a2 got cnt=%0d v=%0b want 0 0", count, out_valid); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) begin
         in_data = 16'(i); in_strobe = 1'b1; tick();
         tests++; if (count !== 5'(i+1) || level_hi !== (i + 1 >= 8)) begin fails++;
            $display("FAIL fill_%0d got cnt=%0d lvl=%0b want %0d %0b", i, count, level_hi, i+1, (i+1 >= 8)); end
      end
      in_data = 16'hFFFF; in_strobe = 1'b1; tick();
      tests++; if (count !== 5'd16 || overflow !== 1'b1 || dropped !== 8'd1) begin fails++;
         $display("FAIL fill_drop got cnt=%0d ovf=%0b drp=%0d want 16 1 1", count, overflow, dropped); end
      for (int i = 0; i < 16; i++) begin
         tests++; if (out_data !== 16'(i) || out_valid !== 1'b1) begin fails++;
            $display("FAIL drain_%0d got data=%h v=%0b want %h 1", i, out_data, out_valid, 16'(i)); end
         out_accept = 1'b1; tick();
         tests++; if (level_hi !== (15 - i >= 8)) begin fails++;
            $display("FAIL drain_lvl_%0d got %0b want %0b", i, level_hi, (15 - i >= 8)); end
      end
      tests++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin fails++;
         $display("FAIL drain_end got v=%0b ovf=%0b want 0 1", out_valid, overflow); end
      overflow_clear = 1'b1; tick();
      tests++; if (overflow !== 1'b0 || dropped !== 8'd0) begin fails++;
         $display("FAIL clear got ovf=%0b drp=%0d want 0 0", overflow, dropped); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) begin
         in_data = 16'(16'h0100 + i); in_strobe = 1'b1; tick();
      end
      in_data = 16'h5555; in_strobe = 1'b1; out_accept = 1'b1; tick();
      tests++; if (count !== 5'd16 || overflow !== 1'b0 || dropped !== 8'd0 || out_data !== 16'h0101) begin fails++;
         $display("FAIL fullpp got cnt=%0d ovf=%0b drp=%0d data=%h want 16 0 0 0101", count, overflow, dropped, out_data); end
      for (int i = 0; i < 16; i++) begin
         tests++; if (out_data !== ((i == 15) ? 16'h5555 : 16'(16'h0101 + i))) begin fails++;
            $display("FAIL fullpp_drain_%0d got %h want %h", i, out_data, ((i == 15) ? 16'h5555 : 16'(16'h0101 + i))); end
         out_accept = 1'b1; tick();
      end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fullpp_empty got %0b want 0", out_valid); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         in_data = 16'(i); in_strobe = 1'b1; tick();
      end
      tests++; if (dropped !== 8'd255 || overflow !== 1'b1 || count !== 5'd16) begin fails++;
         $display("FAIL sat got drp=%0d ovf=%0b cnt=%0d want 255 1 16", dropped, overflow, count); end
      overflow_clear = 1'b1; tick();
      tests++; if (dropped !== 8'd0 || overflow !== 1'b0) begin fails++;
         $display("FAIL sat_clear got drp=%0d ovf=%0b want 0 0", dropped, overflow); end
      in_data = 16'h9999; in_strobe = 1'b1; overflow_clear = 1'b1; tick();
      tests++; if (dropped !== 8'd1 || overflow !== 1'b1) begin fails++;
         $display("FAIL drop_and_clear got drp=%0d ovf=%0b want 1 1", dropped, overflow); end
      tests++; if (out_data !== 16'h0000) begin fails++;
         $display("FAIL sat_head got %h want 0000", out_data); end
      do_reset();
   endtask

   task automatic test_wrap_reset();
      logic [15:0] q[$];
      logic        acc;
      logic        pop;
      logic        full;
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin
            in_data = 16'hDEAD; in_strobe = 1'b1; reset = 1'b1; tick();
            q.delete();
            tests++; if (count !== 5'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin fails++;
               $display("FAIL midreset got cnt=%0d v=%0b data=%h want 0 0 0000", count, out_valid, out_data); end
            in_data = 16'h0042; in_strobe = 1'b1; tick();
            q.push_back(16'h0042);
            tests++; if (count !== 5'd1 || out_valid !== 1'b1 || out_data !== 16'h0042) begin fails++;
               $display("FAIL postreset got cnt=%0d v=%0b data=%h want 1 1 0042", count, out_valid, out_data); end
         end
         acc  = ($urandom_range(3) != 0);
         pop  = acc && (q.size() != 0);
         full = (q.size() == 16);
         in_data = 16'(16'h0200 + i); in_strobe = 1'b1; out_accept = acc;
         if (pop) void'(q.pop_front());
         if (!full || pop) q.push_back(in_data);
         tick();
         tests++; if (count !== 5'(q.size()) || out_data !== q[0]) begin fails++;
            $display("FAIL wrap_%0d got cnt=%0d data=%h want %0d %h", i, count, out_data, q.size(), q[0]); end
      end
      while (q.size() != 0) begin
         out_accept = 1'b1; void'(q.pop_front()); tick();
         tests++; if (count !== 5'(q.size())) begin fails++;
            $display("FAIL wrap_drain got cnt=%0d want %0d", count, q.size()); end
         if (q.size() != 0) begin
            tests++; if (out_data !== q[0]) begin fails++;
               $display("FAIL wrap_drain_data got %h want %h", out_data, q[0]); end
         end
      end
   endtask

   task automatic test_accept_empty();
      for (int i = 0; i < 3; i++) begin
         out_accept = 1'b1; tick();
         tests++; if (count !== 5'd0 || out_valid !== 1'b0 || level_hi !== 1'b0 || overflow !== 1'b0 || dropped !== 8'd0) begin fails++;
            $display("FAIL acc_empty_%0d got cnt=%0d v=%0b lvl=%0b ovf=%0b drp=%0d want 0 0 0 0 0",
                     i, count, out_valid, level_hi, overflow, dropped); end
      end
      in_data = 16'h0777; in_strobe = 1'b1; out_accept = 1'b1; tick();
      tests++; if (count !== 5'd1 || out_data !== 16'h0777) begin fails++;
         $display("FAIL empty_pp got cnt=%0d data=%h want 1 0777", count, out_data); end
      in_data = 16'h0888; in_strobe = 1'b1; tick();
      out_accept = 1'b1; tick();
      tests++; if (count !== 5'd1 || out_data !== 16'h0888) begin fails++;
         $display("FAIL empty_order got cnt=%0d data=%h want 1 0888", count, out_data); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_full_push_pop();
      test_saturate();
      test_wrap_reset();
      do_reset();
      test_accept_empty();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
